// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the CPU memory path and a
// loader/DMA port. One access per clock, round-robin on ties, with a bounded
// loader burst lock so the CPU is never starved. Read data comes back one
// cycle after the grant and is steered to the requester that owns it.
module ram_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  // CPU port
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  // Loader port
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  input  logic          ldr_lock,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  // RAM side
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_oe,
  input  logic [DW-1:0] ram_rdata
);

  // Burst counter is 4 bits wide: MAX_BURST is limited to 1..15.
  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  logic       last_ldr_r;     // 1 when the most recent grant went to the loader
  logic [3:0] burst_cnt_r;    // consecutive loader grants while the CPU waits
  logic       rd_pend_cpu_r;  // CPU read issued last cycle
  logic       rd_pend_ldr_r;  // loader read issued last cycle

  logic       cpu_gnt_s;
  logic       ldr_gnt_s;
  logic       lock_win_s;
  logic [3:0] burst_next_s;

  // Loader keeps priority on a tie only while it holds the lock, owned the
  // previous grant and has not yet used up its burst allowance.
  always_comb begin
    lock_win_s = 1'b0;
    if (ldr_lock && last_ldr_r && (burst_cnt_r < MAX_BURST_C)) begin
      lock_win_s = 1'b1;
    end else begin
      lock_win_s = 1'b0;
    end
  end

  // Grant decision: single requester wins outright, ties go to the lock
  // holder or otherwise to the side not granted last. Nothing during reset.
  always_comb begin
    cpu_gnt_s = 1'b0;
    ldr_gnt_s = 1'b0;
    if (!reset) begin
      cpu_gnt_s = 1'b0;
      ldr_gnt_s = 1'b0;
    end else begin
      case ({cpu_req, ldr_req})
        2'b10: cpu_gnt_s = 1'b1;
        2'b01: ldr_gnt_s = 1'b1;
        2'b11: begin
          if (lock_win_s) begin
            ldr_gnt_s = 1'b1;
          end else if (last_ldr_r) begin
            cpu_gnt_s = 1'b1;
          end else begin
            ldr_gnt_s = 1'b1;
          end
        end
        default: begin
          cpu_gnt_s = 1'b0;
          ldr_gnt_s = 1'b0;
        end
      endcase
    end
  end

  // Next burst count: cleared whenever the CPU is served or not waiting,
  // saturating count of loader grants taken while the CPU waits.
  always_comb begin
    burst_next_s = burst_cnt_r;
    if (cpu_gnt_s || !cpu_req) begin
      burst_next_s = 4'd0;
    end else if (ldr_gnt_s) begin
      if (burst_cnt_r >= MAX_BURST_C) begin
        burst_next_s = MAX_BURST_C;
      end else begin
        burst_next_s = burst_cnt_r + 4'd1;
      end
    end else begin
      burst_next_s = burst_cnt_r;
    end
  end

  // Arbitration history and read-pending flags; reset squashes in-flight reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_ldr_r    <= 1'b1;
      burst_cnt_r   <= 4'd0;
      rd_pend_cpu_r <= 1'b0;
      rd_pend_ldr_r <= 1'b0;
    end else begin
      if (cpu_gnt_s || ldr_gnt_s) begin
        last_ldr_r <= ldr_gnt_s;
      end
      burst_cnt_r   <= burst_next_s;
      rd_pend_cpu_r <= cpu_gnt_s & ~cpu_we;
      rd_pend_ldr_r <= ldr_gnt_s & ~ldr_we;
    end
  end

  // RAM drive: mux the granted port onto the RAM bus, zeros when idle.
  always_comb begin
    ram_addr  = {AW{1'b0}};
    ram_wdata = {DW{1'b0}};
    ram_we    = 1'b0;
    ram_oe    = 1'b0;
    if (cpu_gnt_s) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
      ram_oe    = ~cpu_we;
    end else if (ldr_gnt_s) begin
      ram_addr  = ldr_addr;
      ram_wdata = ldr_wdata;
      ram_we    = ldr_we;
      ram_oe    = ~ldr_we;
    end else begin
      ram_addr  = {AW{1'b0}};
      ram_wdata = {DW{1'b0}};
      ram_we    = 1'b0;
      ram_oe    = 1'b0;
    end
  end

  // Requester-facing outputs: grants, stall and steered read data. Reads
  // pending across a reset are suppressed so no stale data is delivered.
  always_comb begin
    cpu_gnt    = cpu_gnt_s;
    ldr_gnt    = ldr_gnt_s;
    cpu_stall  = reset & cpu_req & ~cpu_gnt_s;
    cpu_rvalid = reset & rd_pend_cpu_r;
    ldr_rvalid = reset & rd_pend_ldr_r;
    if (cpu_rvalid) begin
      cpu_rdata = ram_rdata;
    end else begin
      cpu_rdata = {DW{1'b0}};
    end
    if (ldr_rvalid) begin
      ldr_rdata = ram_rdata;
    end else begin
      ldr_rdata = {DW{1'b0}};
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural RAM model.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       ldr_req, ldr_we, ldr_lock, ldr_gnt, ldr_rvalid;
  logic [7:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_we, ram_oe;

  logic [7:0] mem [0:255];
  int n_checks = 0;
  int n_fail   = 0;

  ram_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: write on the edge, read data the cycle after oe.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_oe) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 8'h00; ldr_wdata = 8'h00;
    ldr_lock = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h01] = 8'h11;
    mem[8'h02] = 8'h22;
    ram_rdata = 8'h00;
    idle();
    reset = 1'b0;
    cpu_req = 1'b1; ldr_req = 1'b1; cpu_addr = 8'h55;

    // Reset state: both requests high, nothing issued.
    tick(); tick();
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_ldr_gnt", 32'(ldr_gnt), 32'd0);
    chk("rst_we_oe",   32'({ram_we, ram_oe}), 32'd0);
    chk("rst_addr",    32'(ram_addr), 32'h00);
    chk("rst_stall",   32'(cpu_stall), 32'd0);

    // Test 1: CPU-only read of 0x10.
    idle(); reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    #1;
    chk("t1_gnt",  32'(cpu_gnt), 32'd1);
    chk("t1_oe",   32'({ram_oe, ram_we}), 32'b10);
    chk("t1_addr", 32'(ram_addr), 32'h10);
    tick();
    idle();
    #1;
    chk("t1_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("t1_rdata",  32'(cpu_rdata), 32'hA5);
    chk("t1_lvalid", 32'(ldr_rvalid), 32'd0);
    tick();

    // Test 2: CPU write 0x3C to 0x20, then read it back.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h3C;
    #1;
    chk("t2_we",    32'({ram_we, ram_oe}), 32'b10);
    chk("t2_wdata", 32'(ram_wdata), 32'h3C);
    tick();
    cpu_we = 1'b0; cpu_wdata = 8'h00;
    #1;
    chk("t2_norv", 32'(cpu_rvalid), 32'd0);
    chk("t2_oe",   32'(ram_oe), 32'd1);
    tick();
    idle();
    #1;
    chk("t2_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("t2_rdata",  32'(cpu_rdata), 32'h3C);
    tick();

    // Test 3: both requesters from reset release, no lock -> C,L,C,L,C,L.
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    cpu_req = 1'b1; cpu_addr = 8'h30;
    ldr_req = 1'b1; ldr_addr = 8'h40;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t3_cpu_gnt", 32'(cpu_gnt), 32'((i % 2) == 0));
      chk("t3_ldr_gnt", 32'(ldr_gnt), 32'((i % 2) == 1));
      chk("t3_stall",   32'(cpu_stall), 32'((i % 2) == 1));
      tick();
    end

    // Test 4: loader lock burst, MAX_BURST=4 -> L, L x4, C, L.
    idle(); reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    ldr_req = 1'b1; ldr_lock = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h80; ldr_wdata = 8'h5A;
    for (int i = 0; i < 7; i++) begin
      cpu_req = (i >= 1);
      cpu_addr = 8'h81;
      #1;
      chk("t4_ldr_gnt", 32'(ldr_gnt), 32'(i != 5));
      chk("t4_cpu_gnt", 32'(cpu_gnt), 32'(i == 5));
      tick();
    end
    // Lock dropped: pure round-robin, last grant was loader -> CPU.
    ldr_lock = 1'b0;
    #1;
    chk("t4_unlock_cpu", 32'(cpu_gnt), 32'd1);
    chk("t4_unlock_ram", 32'({ram_addr, ram_oe}), 32'({8'h81, 1'b1}));
    tick();

    // Test 5: alternating reads CPU 0x01, loader 0x02.
    idle();
    cpu_req = 1'b1; cpu_addr = 8'h01;
    #1;
    chk("t5_cpu_gnt", 32'(cpu_gnt), 32'd1);
    tick();
    idle();
    ldr_req = 1'b1; ldr_addr = 8'h02;
    #1;
    chk("t5_ldr_gnt", 32'(ldr_gnt), 32'd1);
    chk("t5_cpu_rv",  32'({cpu_rvalid, ldr_rvalid, cpu_rdata}), 32'({1'b1, 1'b0, 8'h11}));
    chk("t5_ldr_rd0", 32'(ldr_rdata), 32'h00);
    tick();
    idle();
    #1;
    chk("t5_ldr_rv",  32'({ldr_rvalid, cpu_rvalid, ldr_rdata}), 32'({1'b1, 1'b0, 8'h22}));
    chk("t5_cpu_rd0", 32'(cpu_rdata), 32'h00);
    tick();

    // Test 6: reset in the cycle after a CPU read grant.
    cpu_req = 1'b1; cpu_addr = 8'h10;
    ldr_req = 1'b1; ldr_addr = 8'h02;
    #1;
    chk("t6_cpu_gnt", 32'(cpu_gnt), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_rv_squash", 32'({cpu_rvalid, ldr_rvalid}), 32'd0);
    chk("t6_gnts",      32'({cpu_gnt, ldr_gnt}), 32'd0);
    chk("t6_strobes",   32'({ram_we, ram_oe}), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("t6_rv_after", 32'(cpu_rvalid), 32'd0);
    chk("t6_first_tie", 32'({cpu_gnt, ldr_gnt}), 32'b10);
    tick();
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
